// File: rtl/adc128_reader.sv
// adc128_reader: SPI master that scans the ADC128S022 channels round-robin
// and publishes raw 12-bit conversion codes. The address sent in one frame
// selects the conversion returned in the following frame. The first frame
// after reset, or after an idle period, therefore only primes the pipeline.
module adc128_reader #(
    parameter int CLK_DIV = 13,
    parameter int NUM_CH  = 2,
    parameter int GAP_CYC = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 adc_dout,
    output logic                 adc_cs_n,
    output logic                 adc_sclk,
    output logic                 adc_din,
    output logic [12*NUM_CH-1:0] temp_all,
    output logic                 sample_valid,
    output logic [2:0]           sample_ch,
    output logic [11:0]          sample_data,
    output logic                 frame_err
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP_CYC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [2:0]    CH_LAST  = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {ST_GAP, ST_FRAME, ST_DONE} state_t;

    state_t        state_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic [DW-1:0] div_cnt_reg;
    logic          high_half_reg;
    logic [3:0]    bit_cnt_reg;
    logic [15:0]   shift_reg;
    logic [2:0]    next_addr_reg;
    logic [2:0]    rd_ch_reg;
    logic          primed_reg;
    logic          store_now;

    // Address bits ride in bit-periods 2..4, MSB first; everything else is 0.
    function automatic logic din_bit(input logic [3:0] b, input logic [2:0] a);
        case (b)
            4'd2:    return a[2];
            4'd3:    return a[1];
            4'd4:    return a[0];
            default: return 1'b0;
        endcase
    endfunction

    // A completed, primed frame with clean leading zeros is written back.
    assign store_now = (state_reg == ST_DONE) && primed_reg && (shift_reg[15:12] == 4'd0);

    // Frame sequencer: gap timing, SCLK generation, bit capture and publishing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_GAP;
            gap_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            high_half_reg <= 1'b0;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 16'd0;
            next_addr_reg <= 3'd0;
            rd_ch_reg     <= 3'd0;
            primed_reg    <= 1'b0;
            adc_cs_n      <= 1'b1;
            adc_sclk      <= 1'b1;
            adc_din       <= 1'b0;
            sample_valid  <= 1'b0;
            sample_ch     <= 3'd0;
            sample_data   <= 12'd0;
            frame_err     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            case (state_reg)
                ST_GAP: begin
                    adc_cs_n <= 1'b1;
                    adc_sclk <= 1'b1;
                    adc_din  <= 1'b0;
                    if (gap_cnt_reg != GAP_LAST) begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end else if (enable) begin
                        // First low half of bit-period 0 starts now.
                        state_reg     <= ST_FRAME;
                        gap_cnt_reg   <= '0;
                        div_cnt_reg   <= '0;
                        high_half_reg <= 1'b0;
                        bit_cnt_reg   <= 4'd0;
                        adc_cs_n      <= 1'b0;
                        adc_sclk      <= 1'b0;
                        adc_din       <= din_bit(4'd0, next_addr_reg);
                    end else begin
                        // Idling drops the pipeline; the next frame re-primes.
                        primed_reg <= 1'b0;
                    end
                end
                ST_FRAME: begin
                    if (div_cnt_reg != DIV_LAST) begin
                        div_cnt_reg <= div_cnt_reg + 1'b1;
                    end else begin
                        div_cnt_reg <= '0;
                        if (!high_half_reg) begin
                            // Rising SCLK: capture the ADC bit.
                            high_half_reg <= 1'b1;
                            adc_sclk      <= 1'b1;
                            shift_reg     <= {shift_reg[14:0], adc_dout};
                        end else if (bit_cnt_reg == 4'd15) begin
                            state_reg     <= ST_DONE;
                            high_half_reg <= 1'b0;
                            adc_cs_n      <= 1'b1;
                            adc_sclk      <= 1'b1;
                            adc_din       <= 1'b0;
                        end else begin
                            // Falling SCLK: next bit-period, update DIN.
                            high_half_reg <= 1'b0;
                            adc_sclk      <= 1'b0;
                            bit_cnt_reg   <= bit_cnt_reg + 4'd1;
                            adc_din       <= din_bit(bit_cnt_reg + 4'd1, next_addr_reg);
                        end
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_GAP;
                    gap_cnt_reg   <= '0;
                    rd_ch_reg     <= next_addr_reg;
                    next_addr_reg <= (next_addr_reg == CH_LAST) ? 3'd0 : next_addr_reg + 3'd1;
                    if (!primed_reg) begin
                        primed_reg <= 1'b1;
                    end else if (shift_reg[15:12] != 4'd0) begin
                        frame_err <= 1'b1;
                    end else begin
                        sample_valid <= 1'b1;
                        sample_ch    <= rd_ch_reg;
                        sample_data  <= shift_reg[11:0];
                    end
                end
                default: state_reg <= ST_GAP;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [11:0] ch_reg;
            // Latest accepted code for this channel; held between updates.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ch_reg <= 12'd0;
                end else if (store_now && (rd_ch_reg == 3'(gi))) begin
                    ch_reg <= shift_reg[11:0];
                end
            end
            assign temp_all[12*gi +: 12] = ch_reg;
        end
    endgenerate

endmodule

// File: tb/tb_adc128_reader.sv
// Bench for adc128_reader: a 2-channel instance driven by a behavioural
// ADC128S022 model, plus a 3-channel instance used to observe address
// rotation. Expected samples are queued by the stimulus and popped by a
// monitor whenever sample_valid is seen.
module tb_adc128_reader;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        adc_dout;
    logic        adc_cs_n, adc_sclk, adc_din;
    logic [23:0] temp_all;
    logic        sample_valid, frame_err;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;

    logic        reset3 = 1'b1;
    logic        adc_dout3;
    logic        adc_cs_n3, adc_sclk3, adc_din3;
    logic [35:0] temp_all3;
    logic        sample_valid3, frame_err3;
    logic [2:0]  sample_ch3;
    logic [11:0] sample_data3;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adc128_reader #(.CLK_DIV(2), .NUM_CH(2), .GAP_CYC(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
        .temp_all(temp_all), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .frame_err(frame_err)
    );

    adc128_reader #(.CLK_DIV(2), .NUM_CH(3), .GAP_CYC(4)) dut3 (
        .clk(clk), .reset(reset3), .enable(1'b1), .adc_dout(adc_dout3),
        .adc_cs_n(adc_cs_n3), .adc_sclk(adc_sclk3), .adc_din(adc_din3),
        .temp_all(temp_all3), .sample_valid(sample_valid3), .sample_ch(sample_ch3),
        .sample_data(sample_data3), .frame_err(frame_err3)
    );

    assign adc_dout3 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- ADC model for the 2-channel instance ----------------
    logic [11:0] adc_val [2];
    logic [15:0] m_word = 16'd0;
    logic [4:0]  m_bidx = 5'd0;
    logic        m_prev_sclk = 1'b1;
    logic        m_in_frame = 1'b0;
    logic        inject_err = 1'b0;
    logic [2:0]  m_addr = 3'd0;
    logic [2:0]  m_conv_ch = 3'd0;

    assign adc_dout = (!adc_cs_n && !m_bidx[4]) ? m_word[4'd15 - m_bidx[3:0]] : 1'b0;

    always @(negedge clk) begin
        if (adc_cs_n) begin
            if (m_in_frame) begin
                m_conv_ch  = m_addr;
                m_in_frame = 1'b0;
            end
            m_bidx = 5'd0;
        end else begin
            if (!m_in_frame) begin
                m_in_frame = 1'b1;
                m_addr     = 3'd0;
                m_word     = {4'b0000, adc_val[m_conv_ch[0]]};
                if (inject_err) begin
                    m_word[14] = 1'b1;
                    inject_err = 1'b0;
                end
            end
            if (adc_sclk && !m_prev_sclk) begin
                if (m_bidx >= 5'd2 && m_bidx <= 5'd4) m_addr = {m_addr[1:0], adc_din};
                m_bidx = m_bidx + 5'd1;
            end
        end
        m_prev_sclk = adc_sclk;
    end

    // ---------------- scoreboard monitor / frame timing ----------------
    exp_t exp_q[$];
    int   cyc = 0, low_len = 0, rise_cnt = 0, fall_cnt = 0;
    int   last_fall = 0, prev_fall = 0, strobe_cnt = 0, ferr_cnt = 0;
    logic abort_expected = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   idx;
        cyc++;
        if (sample_valid) begin
            strobe_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got ch=%0d data=%0h expected no strobe", sample_ch, sample_data);
            end else begin
                e = exp_q.pop_front();
                idx = int'(e.ch);
                $display("sample ch=%0d data=%03h (expected ch=%0d data=%03h)", sample_ch, sample_data, e.ch, e.data);
                chk("strobe_ch", 32'(sample_ch), 32'(e.ch));
                chk("strobe_data", 32'(sample_data), 32'(e.data));
                chk("temp_slice", 32'(temp_all[idx*12 +: 12]), 32'(e.data));
            end
        end
        if (frame_err) ferr_cnt++;
        if (!adc_cs_n) begin
            low_len++;
            if (low_len == 1) begin
                prev_fall = last_fall;
                last_fall = cyc;
                fall_cnt++;
            end
        end else if (low_len > 0) begin
            if (abort_expected) abort_expected = 1'b0;
            else chk("cs_low_len", low_len, 64);
            low_len = 0;
            rise_cnt++;
        end
    end

    // ---------------- 3-channel address rotation monitor ----------------
    int         exp_addr3 [4] = '{0, 1, 2, 0};
    int         exp_ch3 [4]   = '{0, 1, 2, 0};
    int         frames3 = 0, str3 = 0;
    logic [4:0] b3 = 5'd0;
    logic [2:0] addr3 = 3'd0;
    logic       prev3 = 1'b1, in3 = 1'b0;

    always @(negedge clk) begin
        if (adc_cs_n3) begin
            if (in3) begin
                if (frames3 < 4) begin
                    $display("dut3 frame %0d din address=%0d", frames3, addr3);
                    chk("addr3", 32'(addr3), exp_addr3[frames3]);
                end
                frames3++;
                in3 = 1'b0;
            end
            b3 = 5'd0;
        end else begin
            if (!in3) begin
                in3   = 1'b1;
                addr3 = 3'd0;
            end
            if (adc_sclk3 && !prev3) begin
                if (b3 >= 5'd2 && b3 <= 5'd4) addr3 = {addr3[1:0], adc_din3};
                b3 = b3 + 5'd1;
            end
        end
        prev3 = adc_sclk3;
        if (sample_valid3) begin
            if (str3 < 4) begin
                chk("ch3_lag", 32'(sample_ch3), exp_ch3[str3]);
                chk("data3", 32'(sample_data3), 32'd0);
            end
            str3++;
        end
    end

    // Wait for n frame ends (cs_n rising), bounded, then settle 3 cycles.
    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = rise_cnt + n;
        budget = n * 300;
        while (rise_cnt < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (rise_cnt < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_frames_timeout: got %0d frames expected %0d", rise_cnt, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_bit(input int b);
        int budget;
        budget = 400;
        while (!(m_in_frame && int'(m_bidx) == b) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_bit_timeout: got bit %0d expected %0d", m_bidx, b);
        end
    endtask

    initial begin
        int falls;
        adc_val[0] = 12'h0A5;
        adc_val[1] = 12'hF3C;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("rst_sclk", 32'(adc_sclk), 32'd1);
        chk("rst_din", 32'(adc_din), 32'd0);
        chk("rst_temp_all", 32'(temp_all), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_ch", 32'(sample_ch), 32'd0);
        chk("rst_data", 32'(sample_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        reset  = 1'b0;
        reset3 = 1'b0;
        enable = 1'b1;

        // Priming frame, then ch0 and ch1.
        wait_frames(1);
        chk("prime_no_strobe", strobe_cnt, 0);
        exp_q.push_back('{ch: 3'd0, data: 12'h0A5});
        exp_q.push_back('{ch: 3'd1, data: 12'hF3C});
        wait_frames(2);
        chk("strobes_after_2", strobe_cnt, 2);
        chk("frame_period", last_fall - prev_fall, 69);
        chk("temp_all_pair", 32'(temp_all), 32'hF3C0A5);

        // Leading-bit error on the ch0 frame; ch0 must keep 0x0A5.
        adc_val[0] = 12'h123;
        inject_err = 1'b1;
        exp_q.push_back('{ch: 3'd1, data: 12'hF3C});
        wait_frames(2);
        chk("ferr_count", ferr_cnt, 1);
        chk("strobes_after_err", strobe_cnt, 3);
        chk("temp_ch0_kept", 32'(temp_all[11:0]), 32'h0A5);

        // Value boundaries.
        adc_val[0] = 12'h000;
        adc_val[1] = 12'hFFF;
        exp_q.push_back('{ch: 3'd0, data: 12'h000});
        exp_q.push_back('{ch: 3'd1, data: 12'hFFF});
        wait_frames(2);
        chk("temp_all_bounds", 32'(temp_all), 32'hFFF000);
        chk("sample_data_fff", 32'(sample_data), 32'hFFF);
        chk("sample_ch_last", 32'(sample_ch), 32'd1);

        // Drop enable mid-frame: frame finishes and strobes, then idle.
        adc_val[0] = 12'h5A5;
        exp_q.push_back('{ch: 3'd0, data: 12'h5A5});
        wait_bit(10);
        enable = 1'b0;
        wait_frames(1);
        chk("strobe_after_disable", strobe_cnt, 6);
        falls = fall_cnt;
        repeat (200) @(negedge clk);
        chk("idle_no_frame", fall_cnt, falls);
        chk("idle_cs_high", 32'(adc_cs_n), 32'd1);
        enable = 1'b1;
        wait_frames(1);
        chk("reprime_no_strobe", strobe_cnt, 6);
        exp_q.push_back('{ch: 3'd0, data: 12'h5A5});
        wait_frames(1);
        chk("resume_strobe", strobe_cnt, 7);

        // Reset in bit-period 7.
        wait_bit(7);
        abort_expected = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
        chk("mid_rst_sclk", 32'(adc_sclk), 32'd1);
        chk("mid_rst_temp", 32'(temp_all), 32'd0);
        chk("mid_rst_valid", 32'(sample_valid), 32'd0);
        chk("mid_rst_ch", 32'(sample_ch), 32'd0);
        chk("mid_rst_data", 32'(sample_data), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        adc_val[0] = 12'h7E1;
        repeat (2) @(negedge clk);
        wait_frames(1);
        chk("post_rst_prime", strobe_cnt, 7);
        exp_q.push_back('{ch: 3'd0, data: 12'h7E1});
        wait_frames(1);
        chk("post_rst_strobe", strobe_cnt, 8);
        chk("post_rst_ch1_zero", 32'(temp_all[23:12]), 32'd0);

        chk("queue_empty", exp_q.size(), 0);
        chk("dut3_frames_seen", 32'(frames3 >= 4), 32'd1);
        chk("dut3_strobes_seen", 32'(str3 >= 4), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
